lab4_fetch_unit: RTL
====================

# lab4_fetch_unit

Program-counter and instruction-fetch stage for the single-cycle heart-rate-monitor processor. Drives the byte address into the instruction RAM, takes the returned 16-bit instruction, and resolves BNE/BLTZ branches using register values from the datapath. Adds run/single-step control, halt-on-NOP, and a retired-instruction counter, so the monitor program can be stopped at its terminating NOP and stepped on the bench.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset; must be even.
- HALT_ON_NOP, 1, when 1 an all-zero instruction halts fetch.
- CNT_W, 16, width of the retired-instruction counter.

- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- RUN  in  1  level; 1 = free-run, 0 = step mode.
- STEP  in  1  step request in step mode; acted on at its rising edge.
- RESUME  in  1  level; while HALTED, clears the halt at the next edge.
- INSTR  in  16  instruction from IRAM Q for the current ADDR; combinational, same cycle.
- RS_VAL  in  8  register-file value of INSTR[11:9].
- RT_VAL  in  8  register-file value of INSTR[8:6].
- ADDR  out  8  registered PC (byte address, bit 0 always 0).
- EXEC  out  1  combinational; the current instruction commits this cycle and gates all datapath write enables.
- HALTED  out  1  registered halt flag.
- RETIRED  out  CNT_W  count of committed instructions, saturating.

## Operation
- State: pc[7:0], halted, step_pending, step_q (previous STEP), retired.
- Reset (RESET=0, asynchronous) sets pc=RESET_PC, halted=0, step_pending=0, step_q=0, retired=0. Outputs during and after reset are ADDR=RESET_PC, HALTED=0, RETIRED=0, and EXEC per the rule below.
- Decode: op=INSTR[15:12], off=INSTR[5:0] (signed, in words).
  - BNE (op=4'b1001): taken if RS_VAL != RT_VAL.
  - BLTZ (op=4'b1011): taken if RS_VAL[7]=1.
  - All other opcodes are sequential.
- is_nop = HALT_ON_NOP && INSTR==16'h0000.
- go = RUN | step_pending.
- EXEC = !halted && go && !is_nop.
- next_pc:
  - Branch taken: pc + 2 + {sext(off),1'b0}.
  - Otherwise: pc + 2.
  - All PC arithmetic is 8-bit modulo 256; bit 0 stays 0.
- At each posedge, with priority in this order:
  1. If halted and RESUME=1: set halted=0 and pc=pc+2, stepping past the NOP. This does not count as retired.
  2. Else if halted: hold all state and discard STEP edges.
  3. Else if go and is_nop: set halted=1 and hold pc.
  4. Else if EXEC: set pc=next_pc and increment retired, saturating at all-ones.
  5. Else: hold pc.
- Step handling:
  - step_q <= STEP every cycle.
  - Rising edge (STEP & !step_q) while !RUN and !halted sets step_pending.
  - step_pending clears on any cycle where EXEC=1 or a halt is entered.
  - RUN=1 forces step_pending to 0.
- A step edge arriving while step_pending is already set is absorbed; there is no queueing beyond one step.

## Timing
- Fetch latency is 0 cycles: INSTR is valid combinationally for the current ADDR, and the branch decision is made in the same cycle.
- PC update takes 1 cycle: the new ADDR appears after the posedge where EXEC=1.
- In step mode, exactly one instruction commits, in the cycle after the STEP rising edge is registered. EXEC is high for exactly one cycle per step.
- Halt entry takes 1 cycle: EXEC=0 in the NOP cycle and HALTED=1 from the next edge.
- RESUME with RUN=1: execution continues from pc+2 one cycle later.
- Mid-operation reset: pc, halted, step_pending and retired clear immediately without waiting for CLK. The first fetch after release is RESET_PC.

## Test plan
- Reset release with RUN=1 and straight-line ADDI/SUB instructions: ADDR goes 0x00, 0x02, 0x04, … one per cycle; RETIRED increments by 1 each cycle; HALTED=0.
- At ADDR=0x20, INSTR=16'h91F7 (BNE R7,R0,-9) with RS_VAL=0 and RT_VAL=5: next ADDR=0x10. With RT_VAL=0: next ADDR=0x22.
- At ADDR=0x2C, INSTR=16'hB801 (BLTZ R4,1): RS_VAL=8'hF2 gives next ADDR=0x30; RS_VAL=8'h03 gives 0x2E.
- INSTR=16'h0000 at ADDR=0xA4: EXEC=0, HALTED=1 next cycle, ADDR held for 10 cycles with RETIRED frozen. Pulsing RESUME gives HALTED=0 and ADDR=0xA6.
- RUN=0 with STEP pulsed three times, 5 cycles apart: ADDR advances exactly 3 times, EXEC shows 3 single-cycle pulses, and RETIRED=3. Holding STEP high for 4 cycles yields only one step.
- Wrap and reset: PC=0xFE with a sequential instruction gives next ADDR=0x00. Asserting RESET mid-step, between clock edges, forces ADDR=0x00 and RETIRED=0 immediately, with step_pending cleared.

Source files
------------

// File: rtl/lab4_fetch_unit.sv
// Fetch stage for the heart-rate-monitor processor: PC, BNE/BLTZ resolution,
// run/single-step control, halt-on-NOP and a saturating retired count.
module lab4_fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter bit         HALT_ON_NOP = 1'b1,
  parameter int         CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             RESUME,
  input  logic [15:0]      INSTR,
  input  logic [7:0]       RS_VAL,
  input  logic [7:0]       RT_VAL,
  output logic [7:0]       ADDR,
  output logic             EXEC,
  output logic             HALTED,
  output logic [CNT_W-1:0] RETIRED
);

  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BLTZ = 4'b1011;

  logic [7:0]       pc;
  logic             halted;
  logic             step_pending;
  logic             step_q;
  logic [CNT_W-1:0] retired;

  logic [3:0] op;
  logic [7:0] off_bytes;
  logic [7:0] pc_inc;
  logic [7:0] next_pc;
  logic       taken;
  logic       is_nop;
  logic       go;
  logic       step_rise;

  // Register-select fields are consumed by the register file, not here.
  logic unused_fields;
  assign unused_fields = &{1'b0, INSTR[11:6]};

  always_comb begin
    op        = INSTR[15:12];
    off_bytes = {INSTR[5], INSTR[5:0], 1'b0};
    taken     = ((op == OP_BNE) && (RS_VAL != RT_VAL)) ||
                ((op == OP_BLTZ) && RS_VAL[7]);
    pc_inc    = pc + 8'd2;
    next_pc   = taken ? (pc_inc + off_bytes) : pc_inc;
    is_nop    = HALT_ON_NOP && (INSTR == 16'h0000);
    go        = RUN | step_pending;
    step_rise = STEP & ~step_q;
    EXEC      = ~halted & go & ~is_nop;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc           <= RESET_PC;
      halted       <= 1'b0;
      step_pending <= 1'b0;
      step_q       <= 1'b0;
      retired      <= '0;
    end else begin
      step_q <= STEP;

      if (halted) begin
        if (RESUME) begin
          halted <= 1'b0;
          pc     <= pc_inc;
        end
      end else if (go && is_nop) begin
        halted <= 1'b1;
      end else if (EXEC) begin
        pc <= next_pc;
        if (retired != '1)
          retired <= retired + CNT_W'(1);
      end

      // Only one step is ever outstanding; extra edges are absorbed.
      if (RUN)
        step_pending <= 1'b0;
      else if (!halted) begin
        if (EXEC || (go && is_nop))
          step_pending <= 1'b0;
        else if (step_rise)
          step_pending <= 1'b1;
      end
    end
  end

  assign ADDR    = pc;
  assign HALTED  = halted;
  assign RETIRED = retired;

endmodule
